dmem_responder: RTL and testbench

//  Data-memory responder serving the load/store requests issued by the execute stage.
//  The execute stage computes the effective address (ram_addr) and acts as initiator.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed 64-bit data-memory responder with fixed access latency and a valid/ready response channel.
// Optional DMEM_RESP_PIPE_EN lets a new request be captured in the response handshake cycle.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [63:0] SPAN     = 64'd8 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        capture, commit;

  logic        cap_wen;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wmask;

  logic [63:0] offset;
  logic        in_range;
  logic [ADDR_W-1:0] index;

  logic [63:0] mem [DEPTH];

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both ends.
  assign offset   = cap_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign index    = offset[ADDR_W+2:3];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture    = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
`ifdef DMEM_RESP_PIPE_EN
        req_ready = resp_ready;
        if (resp_ready) begin
          if (req_valid) begin
            capture    = 1'b1;
            cnt_next   = CNT_INIT;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
`else
        if (resp_ready) begin
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      cap_wen    <= 1'b0;
      cap_addr   <= 64'd0;
      cap_wdata  <= 64'd0;
      cap_wmask  <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        cap_wen   <= req_wen;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wmask <= req_wmask;
      end
      if (commit) begin
        resp_err   <= !in_range;
        resp_rdata <= (in_range && !cap_wen) ? mem[index] : 64'd0;
      end
    end
  end

  // Storage is never cleared; a reset landing on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit && cap_wen && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (cap_wmask[i]) begin
          mem[index][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences and a randomized run against a memory model.
// Honours DMEM_RESP_PIPE_EN when choosing the expected back-to-back response spacing.
module tb_dmem_responder;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned LATENCY   = 2;
  localparam logic [63:0] BASE_ADDR = 64'h8000_0000;
  localparam logic [63:0] SPAN      = 64'd8 << ADDR_W;
`ifdef DMEM_RESP_PIPE_EN
  localparam int EXP_GAP = LATENCY + 1;
`else
  localparam int EXP_GAP = LATENCY + 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wmask = 8'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad = 0;

  logic [63:0] model_mem [int];

  typedef struct {
    string       name;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(
    .ADDR_W(ADDR_W),
    .LATENCY(LATENCY),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen(req_wen),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.wmask = wmask; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One full transaction; lat counts edges from the capture edge to the first resp_valid sample.
  task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, output logic [63:0] rdata,
                               output logic err, output int lat);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) checkVal("req_ready wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) checkVal("resp_valid wait", {63'd0, resp_valid}, 64'd1);
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] rdata, input logic err, input int lat,
                             input logic [63:0] exp_rdata, input logic exp_err, input bit check_data);
    if (check_data) checkVal({name, " rdata"}, rdata, exp_rdata);
    checkVal({name, " err"}, {63'd0, err}, {63'd0, exp_err});
    checkVal({name, " latency"}, 64'(lat), 64'(LATENCY + 1));
  endtask

  // Reference behaviour straight from the address/lane rules, independent of any cycle timing.
  task automatic modelAccess(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wmask, output logic [63:0] exp_rdata,
                             output logic exp_err, output bit known);
    logic [63:0] off;
    logic [63:0] word;
    int idx;
    off = addr - BASE_ADDR;
    exp_rdata = 64'd0;
    exp_err = 1'b0;
    known = 1'b1;
    if (off >= SPAN) begin
      exp_err = 1'b1;
    end else begin
      idx = int'(off / 8);
      if (wen) begin
        if (model_mem.exists(idx) || wmask == 8'hFF) begin
          word = model_mem.exists(idx) ? model_mem[idx] : 64'd0;
          for (int b = 0; b < 8; b++)
            if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
          model_mem[idx] = word;
        end
      end else begin
        known = model_mem.exists(idx);
        if (known) exp_rdata = model_mem[idx];
      end
    end
  endtask

  function automatic logic [63:0] poolAddr(input int sel);
    int word;
    word = (sel < 8) ? sel : 1008 + sel;
    return BASE_ADDR + 64'(word) * 64'd8 + 64'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [63:0] rd;
    logic er;
    int lat;
    int n;
    int t[$];
    logic [63:0] exp_rd;
    logic exp_er;
    bit known;
    logic [63:0] addr;

    addVec("store w0",        1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0);
    addVec("store w2",        1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0);
    addVec("load w2",         1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);
    addVec("load w2 unalign", 1'b0, 64'h8000_0015, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);
    addVec("store w2 low",    1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0);
    addVec("load w2 merged",  1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0);
    addVec("store mask0",     1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0);
    addVec("load after mask0",1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0);
    addVec("store w1 zero",   1'b1, 64'h8000_0008, 64'd0, 8'hFF, 64'd0, 1'b0);
    addVec("store w1 edges",  1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 64'd0, 1'b0);
    addVec("load w1",         1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'hFF00_0000_0000_00FF, 1'b0);
    addVec("store last",      1'b1, 64'h8000_1FF8, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'd0, 1'b0);
    addVec("load last",       1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'hFEDC_BA98_7654_3210, 1'b0);
    addVec("load below base", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
    addVec("load past end",   1'b0, 64'h8000_2000, 64'd0, 8'h00, 64'd0, 1'b1);
    addVec("store past end",  1'b1, 64'h8000_2000, 64'h5555_5555_5555_5555, 8'hFF, 64'd0, 1'b1);
    addVec("load w0 no wrap", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
    addVec("load zero addr",  1'b0, 64'h0000_0000, 64'd0, 8'h00, 64'd0, 1'b1);
    addVec("load top addr",   1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    checkVal("reset req_ready", {63'd0, req_ready}, 64'd1);
    checkVal("reset resp_rdata", resp_rdata, 64'd0);
    checkVal("reset resp_err", {63'd0, resp_err}, 64'd0);
    rst = 1'b1;

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat);
      checkOutput(vecs[i].name, rd, er, lat, vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
    end

    $display("[TB] reset during store");
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0000;
    req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("midreset resp_valid", {63'd0, resp_valid}, 64'd0);
    checkVal("midreset req_ready", {63'd0, req_ready}, 64'd1);
    checkVal("midreset resp_rdata", resp_rdata, 64'd0);
    checkVal("midreset resp_err", {63'd0, resp_err}, 64'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 64'h8000_0000, 64'd0, 8'h00, rd, er, lat);
    checkOutput("load after dropped store", rd, er, lat, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

    $display("[TB] response stall");
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkVal("stall resp_valid", {63'd0, resp_valid}, 64'd1);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0010;
    req_wdata = 64'd0; req_wmask = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkVal("stall hold valid", {63'd0, resp_valid}, 64'd1);
      checkVal("stall hold rdata", resp_rdata, 64'h1122_3344_AAAA_AAAA);
      checkVal("stall hold err", {63'd0, resp_err}, 64'd0);
      checkVal("stall req_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkVal("stall released", {63'd0, resp_valid}, 64'd0);
    applyStimulus(1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
    checkOutput("ignored store", rd, er, lat, 64'h1122_3344_AAAA_AAAA, 1'b0, 1'b1);

    $display("[TB] back-to-back loads");
    resp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_1FF8;
    n = 0;
    while (t.size() < 2 && n < 60) begin
      @(posedge clk); #1; n++;
      if (resp_valid) begin
        t.push_back(n);
        checkVal("b2b rdata", resp_rdata, 64'hFEDC_BA98_7654_3210);
        if (t.size() == 2) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (t.size() == 2) checkVal("b2b spacing", 64'(t[1] - t[0]), 64'(EXP_GAP));
    else checkVal("b2b responses", 64'(t.size()), 64'd2);
    repeat (8) @(posedge clk);
    #1;
    resp_ready = 1'b0;

    $display("[TB] randomized run");
    for (int s = 0; s < 16; s++) begin
      addr = poolAddr(s);
      req_wdata = {$urandom, $urandom};
      modelAccess(1'b1, addr, req_wdata, 8'hFF, exp_rd, exp_er, known);
      applyStimulus(1'b1, addr, req_wdata, 8'hFF, rd, er, lat);
      checkOutput("rand init", rd, er, lat, exp_rd, exp_er, 1'b1);
    end
    for (int k = 0; k < 250; k++) begin
      logic wen;
      logic [63:0] wdata;
      logic [7:0] wmask;
      wen = 1'($urandom_range(0, 1));
      wdata = {$urandom, $urandom};
      wmask = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: addr = BASE_ADDR - 64'd8 * 64'($urandom_range(1, 100)) + 64'($urandom_range(0, 7));
        1: addr = BASE_ADDR + SPAN + 64'd8 * 64'($urandom_range(0, 100)) + 64'($urandom_range(0, 7));
        2: addr = {$urandom, $urandom};
        default: addr = poolAddr(int'($urandom_range(0, 15)));
      endcase
      modelAccess(wen, addr, wdata, wmask, exp_rd, exp_er, known);
      applyStimulus(wen, addr, wdata, wmask, rd, er, lat);
      checkOutput("rand", rd, er, lat, exp_rd, exp_er, known);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
